// File: rtl/div_ratio_ctrl_pkg.sv
// Shared clock-control definitions: FSM state encoding, parameter defaults
// and the ratio legality rule used by the divide-ratio controller.
package div_ratio_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_APPLY     = 2'd2,
    ST_SETTLE    = 2'd3
  } ctrl_state_e;

  localparam int DEFAULT_RATIO_DEF = 2;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int EDGE_TIMEOUT_DEF  = 512;

  localparam logic [7:0] MIN_RATIO = 8'd2;

  // Ratios 0 and 1 cannot be produced by the divider.
  function automatic logic ratio_legal(input logic [7:0] ratio);
    return ratio >= MIN_RATIO;
  endfunction

endpackage

// File: rtl/div_edge_det.sv
// Two-flop sampler on the fed-back divided clock with a rising-edge strobe
// in the reference clock domain.
module div_edge_det (
  input  logic i_ref_clk,
  input  logic i_rst_n,
  input  logic i_div_clk,
  output logic o_rise
);

  logic s1;
  logic s2;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_div_clk;
      s2 <= s1;
    end
  end

  assign o_rise = s1 & ~s2;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Divide-ratio change controller: accepts a new ratio, waits for a safe
// divided-clock edge, gates the divider while the ratio is swapped, then settles.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | ready for a request; clk_en follows i_enable
// ST_WAIT_EDGE | divider running, waiting for a div_clk rising edge
// ST_APPLY     | one cycle: pending ratio loaded into o_div_ratio
// ST_SETTLE    | clk_en held low for SETTLE_CYCLES, then done pulse
module div_ratio_ctrl
  import div_ratio_ctrl_pkg::*;
#(
  parameter int DEFAULT_RATIO = DEFAULT_RATIO_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int EDGE_TIMEOUT  = EDGE_TIMEOUT_DEF
) (
  input  logic        i_ref_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_cfg_valid,
  input  logic [7:0]  i_cfg_ratio,
  input  logic        i_div_clk,
  output logic        o_cfg_ready,
  output logic        o_cfg_done,
  output logic        o_cfg_err,
  output logic        o_timeout,
  output logic [31:0] o_div_ratio,
  output logic        o_clk_en
);

  localparam int CNT_MAX = (EDGE_TIMEOUT > SETTLE_CYCLES) ? EDGE_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  ctrl_state_e      state;
  logic [7:0]       pending;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  div_edge_det u_edge_det (
    .i_ref_clk (i_ref_clk),
    .i_rst_n   (i_rst_n),
    .i_div_clk (i_div_clk),
    .o_rise    (rise)
  );

  // One down-counter serves both the edge-wait timeout and the settle period.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      pending     <= '0;
      cnt         <= '0;
      o_div_ratio <= 32'(DEFAULT_RATIO);
      o_clk_en    <= 1'b0;
      o_cfg_ready <= 1'b0;
      o_cfg_done  <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_cfg_done <= 1'b0;
      o_cfg_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_cfg_ready <= 1'b1;
          o_clk_en    <= i_enable;
          if (i_cfg_valid && o_cfg_ready) begin
            if (!ratio_legal(i_cfg_ratio)) begin
              o_cfg_err <= 1'b1;
            end else if (32'(i_cfg_ratio) == o_div_ratio) begin
              o_cfg_done <= 1'b1;
            end else begin
              pending     <= i_cfg_ratio;
              o_cfg_ready <= 1'b0;
              if (o_clk_en) begin
                state <= ST_WAIT_EDGE;
                cnt   <= CNT_W'(EDGE_TIMEOUT - 1);
              end else begin
                state    <= ST_APPLY;
                o_clk_en <= 1'b0;
              end
            end
          end
        end
        ST_WAIT_EDGE: begin
          o_clk_en <= i_enable;
          if (rise || !i_enable || cnt == '0) begin
            // An edge or a disable arriving on the last cycle is not a timeout.
            if (!rise && i_enable) o_timeout <= 1'b1;
            state    <= ST_APPLY;
            o_clk_en <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_APPLY: begin
          o_div_ratio <= 32'(pending);
          cnt         <= CNT_W'(SETTLE_CYCLES - 1);
          o_clk_en    <= 1'b0;
          state       <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state       <= ST_IDLE;
            o_cfg_done  <= 1'b1;
            o_cfg_ready <= 1'b1;
            o_clk_en    <= i_enable;
          end else begin
            cnt      <= cnt - 1'b1;
            o_clk_en <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Randomized bench for div_ratio_ctrl: a transaction-level reference model
// predicts every output on every cycle of each ratio request.
module tb_div_ratio_ctrl;

  localparam int DEF_RATIO = 2;
  localparam int SETTLE    = 2;
  localparam int TIMEOUT   = 512;
  localparam int NEVER     = 1 << 30;

  logic        i_ref_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic [7:0]  i_cfg_ratio = 8'd0;
  logic        i_div_clk = 1'b0;
  logic        o_cfg_ready;
  logic        o_cfg_done;
  logic        o_cfg_err;
  logic        o_timeout;
  logic [31:0] o_div_ratio;
  logic        o_clk_en;

  div_ratio_ctrl #(
    .DEFAULT_RATIO (DEF_RATIO),
    .SETTLE_CYCLES (SETTLE),
    .EDGE_TIMEOUT  (TIMEOUT)
  ) dut (
    .i_ref_clk   (i_ref_clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (i_enable),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_ratio (i_cfg_ratio),
    .i_div_clk   (i_div_clk),
    .o_cfg_ready (o_cfg_ready),
    .o_cfg_done  (o_cfg_done),
    .o_cfg_err   (o_cfg_err),
    .o_timeout   (o_timeout),
    .o_div_ratio (o_div_ratio),
    .o_clk_en    (o_clk_en)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Divided-clock stimulus: stuck low (mode 0) or a square wave.
  int pat_mode = 0;
  int pat_per  = 4;
  int pat_ph   = 0;
  int ecnt     = 0;

  function automatic logic pat(input int e);
    if (pat_mode == 0) return 1'b0;
    return ((e + pat_ph) % pat_per) < (pat_per / 2);
  endfunction

  // Edge ecnt has just passed; i_div_clk is set up for edge ecnt+1.
  task automatic tick();
    @(posedge i_ref_clk);
    #1;
    ecnt++;
    i_div_clk = pat(ecnt + 1);
  endtask

  int cur_ratio = DEF_RATIO;
  bit tflag = 1'b0;

  task automatic do_req(input int r, input bit en, input int drop_k, input bit junk);
    int  kind, a, t_edge, end_k;
    bit  to_cause, inflight, en_prev, exp_en;
    i_enable    = en;
    i_cfg_valid = 1'b0;
    repeat (3) tick();
    check_val("idle_ready", o_cfg_ready, 1);
    check_val("idle_clk_en", o_clk_en, en);
    check_val("idle_ratio", o_div_ratio, cur_ratio);
    i_cfg_valid = 1'b1;
    i_cfg_ratio = 8'(r);
    tick();
    t_edge      = ecnt;
    i_cfg_valid = 1'b0;
    i_cfg_ratio = 8'($urandom);

    kind = (r < 2) ? 0 : ((r == cur_ratio) ? 1 : 2);
    a = 0;
    to_cause = 1'b0;
    if (kind == 2 && en) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        bit rs, ek;
        rs = pat(t_edge + k) && !pat(t_edge + k - 1);
        ek = (k < drop_k);
        if (rs || !ek || k == TIMEOUT - 1) begin
          to_cause = !rs && ek;
          a = k + 1;
          break;
        end
      end
    end
    end_k = (kind == 2) ? a + SETTLE + 3 : 4;

    en_prev = en;
    for (int k = 0; k <= end_k; k++) begin
      bit en_now;
      inflight = (kind == 2) && (k <= a + SETTLE);
      exp_en = en_prev;
      if (kind == 2 && k >= a && k <= a + SETTLE) exp_en = 1'b0;
      check_val($sformatf("err k=%0d r=%0d", k, r), o_cfg_err, (kind == 0 && k == 0));
      check_val($sformatf("done k=%0d r=%0d", k, r), o_cfg_done,
                (kind == 1 && k == 0) || (kind == 2 && k == a + SETTLE + 1));
      check_val($sformatf("ratio k=%0d r=%0d", k, r), o_div_ratio,
                (kind == 2 && k >= a + 1) ? r : cur_ratio);
      check_val($sformatf("ready k=%0d r=%0d", k, r), o_cfg_ready, !inflight);
      check_val($sformatf("clk_en k=%0d r=%0d", k, r), o_clk_en, exp_en);
      check_val($sformatf("timeout k=%0d r=%0d", k, r), o_timeout,
                tflag || (to_cause && k >= a));
      en_now      = en && !(kind == 2 && k >= drop_k);
      i_enable    = en_now;
      en_prev     = en_now;
      i_cfg_valid = junk && inflight && ($urandom % 2 == 1);
      i_cfg_ratio = 8'($urandom);
      if (k < end_k) tick();
    end
    i_cfg_valid = 1'b0;
    if (kind == 2) cur_ratio = r;
    tflag = tflag || to_cause;
  endtask

  initial begin
    int r, sel, drop_k, mid_r;
    bit en;

    i_rst_n = 1'b0;
    repeat (5) tick();
    check_val("rst_ratio", o_div_ratio, DEF_RATIO);
    check_val("rst_clk_en", o_clk_en, 0);
    check_val("rst_ready", o_cfg_ready, 0);
    check_val("rst_done", o_cfg_done, 0);
    check_val("rst_err", o_cfg_err, 0);
    check_val("rst_timeout", o_timeout, 0);
    i_rst_n = 1'b1;
    tick();
    check_val("rel_ready", o_cfg_ready, 1);
    check_val("rel_ratio", o_div_ratio, DEF_RATIO);
    check_val("rel_clk_en", o_clk_en, 0);

    do_req(1, 1'b0, NEVER, 1'b0);
    do_req(0, 1'b1, NEVER, 1'b0);
    do_req(2, 1'b1, NEVER, 1'b0);

    pat_mode = 1; pat_per = 4; pat_ph = 1;
    do_req(4, 1'b1, NEVER, 1'b1);
    do_req(6, 1'b1, NEVER, 1'b1);

    pat_mode = 0;
    do_req(5, 1'b1, NEVER, 1'b0);
    check_val("timeout_sticky", o_timeout, 1);
    check_val("timeout_ratio", o_div_ratio, 5);

    do_req(7, 1'b0, NEVER, 1'b1);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom % 10;
      if (sel < 2)      r = $urandom % 2;
      else if (sel < 4) r = cur_ratio;
      else              r = $urandom_range(2, 255);
      en = ($urandom % 2 == 1);
      if ($urandom % 8 == 0) begin
        pat_mode = 0;
      end else begin
        pat_mode = 1;
        pat_per  = $urandom_range(2, 12);
        pat_ph   = $urandom % pat_per;
      end
      drop_k = ($urandom % 3 == 0) ? $urandom_range(0, 8) : NEVER;
      do_req(r, en, drop_k, ($urandom % 2 == 1));
    end

    do_req(11, 1'b0, NEVER, 1'b0);
    pat_mode = 0;
    mid_r = (cur_ratio == 9) ? 10 : 9;
    i_enable = 1'b1;
    repeat (3) tick();
    i_cfg_valid = 1'b1;
    i_cfg_ratio = 8'(mid_r);
    tick();
    i_cfg_valid = 1'b0;
    repeat (10) tick();
    check_val("mid_wait_ready", o_cfg_ready, 0);
    check_val("mid_wait_clk_en", o_clk_en, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_val("mid_rst_ratio", o_div_ratio, DEF_RATIO);
    check_val("mid_rst_ready", o_cfg_ready, 0);
    check_val("mid_rst_clk_en", o_clk_en, 0);
    check_val("mid_rst_timeout", o_timeout, 0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    cur_ratio = DEF_RATIO;
    tflag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_val($sformatf("post_rst_done k=%0d", k), o_cfg_done, 0);
      check_val($sformatf("post_rst_ready k=%0d", k), o_cfg_ready, 1);
      check_val($sformatf("post_rst_ratio k=%0d", k), o_div_ratio, DEF_RATIO);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ratio_ctrl.md
DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_RATIO, default 2: divide ratio driven out of reset.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: cycles o_clk_en is held low after a ratio change.
REQ-003 SHALL have parameter EDGE_TIMEOUT, default 512: maximum cycles spent waiting for a divided-clock rising edge.
REQ-004 SHALL have port i_ref_clk, input, 1 bit: reference clock; every flop is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_enable, input, 1 bit: software enable for the divider.
REQ-007 SHALL have port i_cfg_valid, input, 1 bit: new-ratio request valid.
REQ-008 SHALL have port i_cfg_ratio, input, 8 bits: requested divide ratio.
REQ-009 SHALL have port i_div_clk, input, 1 bit: divided clock fed back from the divider output.
REQ-010 SHALL have port o_cfg_ready, output, 1 bit: ready to accept a request.
REQ-011 SHALL have port o_cfg_done, output, 1 bit: one-cycle pulse when a request has completed.
REQ-012 SHALL have port o_cfg_err, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-013 SHALL have port o_timeout, output, 1 bit: sticky flag, set when an edge wait timed out.
REQ-014 SHALL have port o_div_ratio, output, 32 bits: ratio to the divider.
REQ-015 SHALL have port o_clk_en, output, 1 bit: registered enable to the divider.

Function
REQ-016 SHALL use a handshake in which a request transfers on the cycle i_cfg_valid=1 and o_cfg_ready=1; o_cfg_ready SHALL be 1 only in state IDLE.
REQ-017 SHALL implement FSM states IDLE, WAIT_EDGE, APPLY and SETTLE, with next state registered.
REQ-018 SHALL reject a transferred ratio below 2: o_cfg_err pulses the next cycle, state stays IDLE, o_div_ratio is unchanged.
REQ-019 SHALL treat a transferred ratio equal to the current o_div_ratio as a no-op: o_cfg_done pulses the next cycle, state stays IDLE.
REQ-020 SHALL, for any other legal ratio, latch it into a pending register; next state is APPLY if o_clk_en=0, otherwise WAIT_EDGE.
REQ-021 SHALL, in WAIT_EDGE, sample i_div_clk through two flops (s1, s2) and define a rising edge as s1=1 and s2=0.
REQ-022 SHALL leave WAIT_EDGE for APPLY on the first of three events: a rising edge, i_enable=0, or the wait counter reaching EDGE_TIMEOUT-1.
REQ-023 SHALL set o_timeout on the cycle the timeout event occurs; o_timeout is cleared only by reset.
REQ-024 SHALL, in APPLY, last exactly one cycle, during which o_div_ratio is loaded with the zero-extended pending ratio and the state moves to SETTLE.
REQ-025 SHALL, in SETTLE, count SETTLE_CYCLES cycles, then return to IDLE and pulse o_cfg_done on the same cycle.
REQ-026 SHALL compute o_clk_en (registered) as i_enable AND (next state is neither APPLY nor SETTLE); o_clk_en is therefore 0 throughout APPLY and SETTLE.
REQ-027 SHALL give i_cfg_valid no effect outside IDLE; no request is queued.
REQ-028 SHALL ignore changes on i_cfg_ratio while a request is in flight, because the pending register holds the captured value.
REQ-029 SHALL never assert o_cfg_done and o_cfg_err in the same cycle.

Reset
REQ-030 SHALL, while i_rst_n=0, force the state to IDLE and set o_div_ratio=DEFAULT_RATIO, o_clk_en=0, o_cfg_ready=0, o_cfg_done=0, o_cfg_err=0 and o_timeout=0, and clear every counter and the sync flops.
REQ-031 SHALL deassert o_cfg_ready during reset and drive o_cfg_ready=1 from the first clock after reset release.
REQ-032 SHALL abort any request in flight on a reset asserted mid-operation, restoring o_div_ratio to DEFAULT_RATIO with no o_cfg_done pulse.

Structure
REQ-033 SHALL place the FSM state encodings, DEFAULT_RATIO, SETTLE_CYCLES and EDGE_TIMEOUT defaults in the shared clock-control package/include.
REQ-034 SHALL implement the two-flop sampler and rising-edge detect as one sub-module, div_edge_det.
REQ-035 SHALL connect o_div_ratio and o_clk_en directly to the divider's ratio and clock-enable inputs, and feed the divider output back on i_div_clk.

Verification
REQ-036 SHALL be verified for reset defaults: hold reset 5 cycles, release -> o_div_ratio=2, o_clk_en=0, o_cfg_ready=1 on the first clock after release.
REQ-037 SHALL be verified for illegal ratio: i_cfg_ratio=1 with valid -> o_cfg_err pulses for 1 cycle, o_div_ratio stays 2.
REQ-038 SHALL be verified for running change: i_enable=1, divider at 4, request 6 -> o_clk_en low 1+2 cycles starting after a div_clk rising edge, then o_div_ratio=6 and o_cfg_done pulses.
REQ-039 SHALL be verified for timeout: i_div_clk tied 0, i_enable=1, request 5 -> APPLY after 512 cycles, o_timeout=1, o_div_ratio=5.
REQ-040 SHALL be verified for a disabled path: i_enable=0, request 7 -> o_div_ratio=7 two cycles after the transfer, o_cfg_done after SETTLE.
REQ-041 SHALL be verified for mid-operation reset: assert reset during WAIT_EDGE -> o_div_ratio=2, no o_cfg_done pulse, state IDLE.
